sad_best_select: RTL and testbench

- Downstream stage of the per-row SAD adder.
- Consumes one 60-bit row SAD vector per accepted beat: five 12-bit candidate sums, in the order h, q, f, r, i.
- Accumulates each candidate over ROWS rows of a block, then scans the five totals sequentially and returns the minimum-SAD candidate index and value through a valid/ready output handshake.

---
 rtl/sad_best_select.sv | 133 +++++++++++++
 tb/tb_sad_best_select.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_best_select.sv
// Accumulates five candidate SADs over ROWS rows, then scans the totals one per
// cycle and presents the minimum-SAD candidate through a valid/ready handshake.
module sad_best_select #(
    parameter int ROWS  = 6,
    parameter int ACC_W = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [59:0]          sad_vector,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           best_idx,
    output logic [ACC_W-1:0]     best_sad,
    output logic [5*ACC_W-1:0]   sad_acc
);

    typedef enum logic [1:0] {
        S_ACC,
        S_CMP,
        S_OUT
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [7:0]       LAST_ROW = 8'(ROWS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       row_cnt;
    logic [2:0]       cmp_idx;
    logic [ACC_W-1:0] acc [5];
    logic [ACC_W-1:0] cmp_acc;
    logic             accept;
    logic             last_row;
    logic             cmp_done;

    // Saturates once the running total passes the accumulator range.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [11:0]      b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W + 1 - 12){1'b0}}, b};
        return s[ACC_W] ? ACC_MAX : s[ACC_W-1:0];
    endfunction

    assign accept   = in_valid & in_ready;
    assign last_row = (row_cnt == LAST_ROW);
    assign cmp_done = (cmp_idx == 3'd4);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_ACC;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_ACC:   if (accept && last_row) state_nxt = S_CMP;
            S_CMP:   if (cmp_done)           state_nxt = S_OUT;
            S_OUT:   if (out_ready)          state_nxt = S_ACC;
            default:                         state_nxt = S_ACC;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_ACC);
        out_valid = (state == S_OUT);
    end

    always_comb begin
        cmp_acc = acc[0];
        case (cmp_idx)
            3'd1:    cmp_acc = acc[1];
            3'd2:    cmp_acc = acc[2];
            3'd3:    cmp_acc = acc[3];
            3'd4:    cmp_acc = acc[4];
            default: cmp_acc = acc[0];
        endcase
    end

    // NOTE: the accumulator array is reset explicitly; a reset mid-block must
    // discard partial sums, so it cannot be left to power-up contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt  <= '0;
            cmp_idx  <= '0;
            best_idx <= '0;
            best_sad <= '0;
            for (int k = 0; k < 5; k++) acc[k] <= '0;
        end else begin
            case (state)
                S_ACC: begin
                    if (accept) begin
                        for (int k = 0; k < 5; k++)
                            acc[k] <= sat_add(acc[k], sad_vector[k*12 +: 12]);
                        if (last_row) begin
                            row_cnt <= '0;
                            cmp_idx <= '0;
                        end else begin
                            row_cnt <= row_cnt + 8'd1;
                        end
                    end
                end
                S_CMP: begin
                    // Strict less-than keeps the lower index on ties.
                    if (cmp_idx == 3'd0) begin
                        best_sad <= acc[0];
                        best_idx <= 3'd0;
                    end else if (cmp_acc < best_sad) begin
                        best_sad <= cmp_acc;
                        best_idx <= cmp_idx;
                    end
                    cmp_idx <= cmp_done ? 3'd0 : cmp_idx + 3'd1;
                end
                S_OUT: begin
                    if (out_ready)
                        for (int k = 0; k < 5; k++) acc[k] <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sad_acc = '0;
        for (int k = 0; k < 5; k++) sad_acc[k*ACC_W +: ACC_W] = acc[k];
    end

endmodule

// File: tb/tb_sad_best_select.sv
// Scoreboard bench: directed blocks push expected results; a negedge monitor
// checks each presented result, its latency, hold stability and post-handshake state.
module tb_sad_best_select;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [59:0] sad_vector;
    logic        sel;

    // DUT a: default widths; DUT b: ACC_W=12 for saturation.
    logic        in_ready_a, out_valid_a;
    logic [2:0]  best_idx_a;
    logic [14:0] best_sad_a;
    logic [74:0] sad_acc_a;
    logic        in_ready_b, out_valid_b;
    logic [2:0]  best_idx_b;
    logic [11:0] best_sad_b;
    logic [59:0] sad_acc_b;

    sad_best_select #(.ROWS(6), .ACC_W(15)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid & ~sel),
        .in_ready   (in_ready_a),
        .sad_vector (sad_vector),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready & ~sel),
        .best_idx   (best_idx_a),
        .best_sad   (best_sad_a),
        .sad_acc    (sad_acc_a)
    );

    sad_best_select #(.ROWS(6), .ACC_W(12)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid & sel),
        .in_ready   (in_ready_b),
        .sad_vector (sad_vector),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready & sel),
        .best_idx   (best_idx_b),
        .best_sad   (best_sad_b),
        .sad_acc    (sad_acc_b)
    );

    always #5 clk = ~clk;

    logic        m_ir, m_ov;
    logic [2:0]  m_idx;
    logic [23:0] m_sad;
    logic [23:0] m_acc [5];

    always_comb begin
        m_ir  = sel ? in_ready_b  : in_ready_a;
        m_ov  = sel ? out_valid_b : out_valid_a;
        m_idx = sel ? best_idx_b  : best_idx_a;
        m_sad = sel ? 24'(best_sad_b) : 24'(best_sad_a);
        for (int k = 0; k < 5; k++)
            m_acc[k] = sel ? 24'(sad_acc_b[k*12 +: 12]) : 24'(sad_acc_a[k*15 +: 15]);
    end

    typedef struct packed {
        logic [2:0]       idx;
        logic [23:0]      sad;
        logic [4:0][23:0] acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input int idx, input int sad, input int a0, input int a1,
                            input int a2, input int a3, input int a4);
        exp_t e;
        e.idx    = 3'(idx);
        e.sad    = 24'(sad);
        e.acc[0] = 24'(a0);
        e.acc[1] = 24'(a1);
        e.acc[2] = 24'(a2);
        e.acc[3] = 24'(a3);
        e.acc[4] = 24'(a4);
        exp_q.push_back(e);
    endtask

    function automatic logic [59:0] vec(input int h, input int q, input int f,
                                        input int r, input int i);
        return {12'(i), 12'(r), 12'(f), 12'(q), 12'(h)};
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: pops on first appearance of out_valid, then checks stability.
    int          last_acc = 0;
    bit          held     = 0;
    bit          prev_hs  = 0;
    exp_t        cur;
    logic [2:0]  snap_idx;
    logic [23:0] snap_sad;
    logic [23:0] snap_acc [5];

    always @(negedge clk) begin
        if (!rst_n) begin
            held    = 0;
            prev_hs = 0;
        end else begin
            if (in_valid && m_ir) last_acc = cyc + 1;
            if (prev_hs) begin
                check("post_hs_out_valid", 32'(m_ov), 0);
                check("post_hs_in_ready", 32'(m_ir), 1);
                for (int k = 0; k < 5; k++)
                    check($sformatf("post_hs_acc%0d", k), 32'(m_acc[k]), 0);
                prev_hs = 0;
            end
            if (m_ov) begin
                check("out_in_ready", 32'(m_ir), 0);
                if (!held) begin
                    check("latency", 32'(cyc), 32'(last_acc + 5));
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: got out_valid=1, expected no result (t=%0t)", $time);
                    end else begin
                        cur = exp_q.pop_front();
                        check("best_idx", 32'(m_idx), 32'(cur.idx));
                        check("best_sad", 32'(m_sad), 32'(cur.sad));
                        for (int k = 0; k < 5; k++)
                            check($sformatf("sad_acc%0d", k), 32'(m_acc[k]), 32'(cur.acc[k]));
                    end
                    held     = 1;
                    snap_idx = m_idx;
                    snap_sad = m_sad;
                    for (int k = 0; k < 5; k++) snap_acc[k] = m_acc[k];
                end else begin
                    check("hold_idx", 32'(m_idx), 32'(snap_idx));
                    check("hold_sad", 32'(m_sad), 32'(snap_sad));
                    for (int k = 0; k < 5; k++)
                        check($sformatf("hold_acc%0d", k), 32'(m_acc[k]), 32'(snap_acc[k]));
                end
                if (out_ready) begin
                    held    = 0;
                    prev_hs = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [59:0] v);
        int t = 0;
        in_valid   = 1'b1;
        sad_vector = v;
        while (!m_ir && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) check("in_ready_timeout", 32'(m_ir), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [59:0] v, input int n, input bit gap);
        repeat (n) begin
            send_row(v);
            if (gap) tick();
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || m_ov) && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) check("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        sel        = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        sad_vector = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("rst_in_ready", 32'(m_ir), 1);
        check("rst_out_valid", 32'(m_ov), 0);
        check("rst_best_idx", 32'(m_idx), 0);
        check("rst_best_sad", 32'(m_sad), 0);
        for (int k = 0; k < 5; k++) check($sformatf("rst_acc%0d", k), 32'(m_acc[k]), 0);
        tick();

        // Basic and tie-break blocks, back to back.
        push_exp(2, 480, 600, 540, 480, 570, 720);
        send_block(vec(100, 90, 80, 95, 120), 6, 0);
        push_exp(0, 300, 300, 300, 300, 300, 300);
        send_block(vec(50, 50, 50, 50, 50), 6, 0);
        push_exp(1, 240, 360, 240, 420, 240, 240);
        send_block(vec(60, 40, 70, 40, 40), 6, 0);
        drain();

        // Gapped input, held output, junk rows presented during the hold.
        out_ready = 1'b0;
        push_exp(2, 480, 600, 540, 480, 570, 720);
        send_block(vec(100, 90, 80, 95, 120), 6, 1);
        t = 0;
        while (!m_ov && t < 50) begin
            tick();
            t++;
        end
        check("bp_out_valid_seen", 32'(m_ov), 1);
        in_valid   = 1'b1;
        sad_vector = vec(1, 1, 1, 1, 1);
        repeat (10) tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        push_exp(1, 240, 360, 240, 420, 240, 240);
        send_block(vec(60, 40, 70, 40, 40), 6, 0);
        drain();

        // Reset mid-block.
        send_block(vec(1000, 1000, 1000, 1000, 1000), 3, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        push_exp(4, 6, 30, 24, 18, 12, 6);
        send_block(vec(5, 4, 3, 2, 1), 6, 0);
        drain();

        // Reset during the compare scan: no result may appear.
        send_block(vec(1000, 1000, 1000, 1000, 1000), 6, 0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("abort_no_out_valid", 32'(m_ov), 0);
        push_exp(2, 480, 600, 540, 480, 570, 720);
        send_block(vec(100, 90, 80, 95, 120), 6, 0);
        drain();

        // Saturation on the ACC_W=12 instance.
        sel = 1'b1;
        tick();
        push_exp(4, 60, 4095, 4095, 4095, 4095, 60);
        send_block(vec(4095, 4095, 4095, 4095, 10), 6, 0);
        drain();

        check("queue_empty", 32'(exp_q.size()), 0);
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
